// File: rtl/pattern_gen_pkg.sv
// Shared types, constants and helpers for the "010" pattern generator and its serial counter.
package pattern_gen_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [2:0] PATTERN = 3'b010;

    // Largest occurrence count that fits in a word of the given width.
    function automatic int max_count(input int width);
        return (width - 1) / 2;
    endfunction

endpackage

// File: rtl/pattern_ser_count.sv
// Streaming "010" occurrence counter: consumes one bit per valid beat, LSB of the word first.
module pattern_ser_count
    import pattern_gen_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             bit_vld,
    input  logic             bit_in,
    output logic [CNT_W-1:0] count
);

    logic [2:0] hist;
    logic [2:0] window;

    // hist[0] is the oldest bit; the all-ones seed stops the first two beats matching.
    assign window = {bit_in, hist[2:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist  <= 3'b111;
            count <= '0;
        end else if (clr) begin
            hist  <= 3'b111;
            count <= '0;
        end else if (bit_vld) begin
            hist <= window;
            if (window == PATTERN) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pattern_gen.sv
// Builds a word holding exactly N "010" occurrences at offset OFF and streams it LSB-first.
// Optional macro PATTERN_GEN_SELFCHECK_EN adds a serial recount of the emitted beats and chk_fail.
module pattern_gen
    import pattern_gen_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 4,
    parameter int OFF_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_count,
    input  logic [OFF_W-1:0] req_offset,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_bit,
    output logic             ser_last,
    output logic [WIDTH-1:0] word_out,
    output logic             done,
    output logic             err
`ifdef PATTERN_GEN_SELFCHECK_EN
    ,
    output logic             chk_fail
`endif
);

    localparam int MAX_N = max_count(WIDTH);
    localparam int SUM_W = ((OFF_W > CNT_W) ? OFF_W : CNT_W) + 2;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] word_p0;
    logic [WIDTH-1:0] built;
    logic [OFF_W-1:0] idx_p0;
    logic [OFF_W-1:0] idx_inc;
    logic [SUM_W-1:0] need;
    logic             legal;
    logic             load, reject, beat, finish;

    // Bit OFF+2k+1 is set for k < N; every set bit is the centre of one "010".
    function automatic logic [WIDTH-1:0] build_word(input logic [CNT_W-1:0] n,
                                                    input logic [OFF_W-1:0] off);
        logic [WIDTH-1:0] w;
        int o, k;
        o = int'(off);
        k = int'(n);
        w = '0;
        for (int j = 0; j < WIDTH; j++) begin
            if (j > o && ((j - o - 1) % 2) == 0 && ((j - o - 1) / 2) < k) begin
                w[j] = 1'b1;
            end
        end
        return w;
    endfunction

    assign built     = build_word(req_count, req_offset);
    assign need      = SUM_W'(req_offset) + SUM_W'({req_count, 1'b0}) + SUM_W'(1);
    assign legal     = (need <= SUM_W'(WIDTH)) && (int'(req_count) <= MAX_N);
    assign req_ready = (state == IDLE);
    assign idx_inc   = idx_p0 + OFF_W'(1);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        reject    = 1'b0;
        beat      = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (legal) begin
                        load      = 1'b1;
                        state_nxt = SHIFT;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (ser_valid && ser_ready) begin
                    beat = 1'b1;
                    if (ser_last) begin
                        finish    = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stream stage: ser_bit/ser_last are registered and only advance on an accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_p0   <= '0;
            idx_p0    <= '0;
            ser_valid <= 1'b0;
            ser_bit   <= 1'b0;
            ser_last  <= 1'b0;
            word_out  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= finish;
            err  <= reject;
            if (load) begin
                word_p0   <= built;
                idx_p0    <= '0;
                ser_valid <= 1'b1;
                ser_bit   <= built[0];
                ser_last  <= 1'b0;
            end else if (finish) begin
                idx_p0    <= '0;
                ser_valid <= 1'b0;
                ser_bit   <= 1'b0;
                ser_last  <= 1'b0;
                word_out  <= word_p0;
            end else if (beat) begin
                idx_p0   <= idx_inc;
                ser_bit  <= word_p0[idx_inc];
                ser_last <= (idx_inc == OFF_W'(WIDTH - 1));
            end
        end
    end

`ifdef PATTERN_GEN_SELFCHECK_EN
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] chk_cnt;

    pattern_ser_count #(.CNT_W(CNT_W)) u_chk (
        .clk     (clk),
        .rst     (rst),
        .clr     (load),
        .bit_vld (beat),
        .bit_in  (ser_bit),
        .count   (chk_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_lat <= '0;
        end else if (load) begin
            n_lat <= req_count;
        end
    end

    // The recount already includes the final beat in the cycle done is high.
    assign chk_fail = done && (chk_cnt != n_lat);
`endif

endmodule

// File: tb/tb_pattern_gen.sv
// Randomised self-checking bench for pattern_gen against a word/occurrence reference model.
module tb_pattern_gen;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;
    localparam int OFF_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [CNT_W-1:0] req_count;
    logic [OFF_W-1:0] req_offset;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_bit;
    logic             ser_last;
    logic [WIDTH-1:0] word_out;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] rx_count;
`ifdef PATTERN_GEN_SELFCHECK_EN
    logic             chk_fail;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] model_out = '0;

    always #5 clk = ~clk;

    pattern_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .OFF_W(OFF_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_count  (req_count),
        .req_offset (req_offset),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .ser_bit    (ser_bit),
        .ser_last   (ser_last),
        .word_out   (word_out),
        .done       (done),
        .err        (err)
`ifdef PATTERN_GEN_SELFCHECK_EN
        ,
        .chk_fail   (chk_fail)
`endif
    );

    // Independent receiver on the emitted stream.
    pattern_ser_count #(.CNT_W(CNT_W)) u_rx (
        .clk     (clk),
        .rst     (rst),
        .clr     (req_valid && req_ready),
        .bit_vld (ser_valid && ser_ready),
        .bit_in  (ser_bit),
        .count   (rx_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_word(input int n, input int off);
        logic [WIDTH-1:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w = w | (WIDTH'(1) << (off + 2 * k + 1));
        return w;
    endfunction

    function automatic bit model_legal(input int n, input int off);
        return (off + 2 * n + 1) <= WIDTH;
    endfunction

    function automatic int model_count(input logic [WIDTH-1:0] w);
        int c;
        c = 0;
        for (int i = 0; i <= WIDTH - 3; i++)
            if (w[i] == 1'b0 && w[i+1] == 1'b1 && w[i+2] == 1'b0) c++;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rmode: 0 = always ready, 1 = ready pattern 1,0,0, 2 = random ready.
    task automatic run_req(input int n, input int off, input int rmode);
        logic [WIDTH-1:0] exp;
        logic [WIDTH-1:0] got_word;
        int beats, last_at, n_last, hold_bad, vld_bad, early_done, cyc;
        logic pb, pl, v, r;
        bit stalled;

        req_valid  = 1'b1;
        req_count  = CNT_W'(n);
        req_offset = OFF_W'(off);
        tick();
        req_valid = 1'b0;

        if (!model_legal(n, off)) begin
            chk("err_pulse", 64'(err), 64'(1));
            chk("rej_no_stream", 64'(ser_valid), 64'(0));
            chk("rej_ready", 64'(req_ready), 64'(1));
            tick();
            chk("err_one_cycle", 64'(err), 64'(0));
            chk("rej_word_kept", 64'(word_out), 64'(model_out));
            return;
        end

        exp = model_word(n, off);
        chk("first_valid", 64'(ser_valid), 64'(1));
        beats = 0; last_at = -1; n_last = 0; hold_bad = 0; vld_bad = 0;
        early_done = 0; cyc = 0; stalled = 0; got_word = '0;
        pb = 1'b0; pl = 1'b0;

        while (beats < WIDTH && cyc < 4000) begin
            if (stalled && (ser_bit !== pb || ser_last !== pl)) hold_bad++;
            if (!ser_valid) vld_bad++;
            if (done) early_done++;
            case (rmode)
                0:       r = 1'b1;
                1:       r = ((cyc % 3) == 0);
                default: r = 1'($urandom % 2);
            endcase
            ser_ready = r;
            v  = ser_valid;
            pb = ser_bit;
            pl = ser_last;
            tick();
            if (r && v) begin
                got_word[beats] = pb;
                if (pl) begin
                    last_at = beats;
                    n_last++;
                end
                beats++;
                stalled = 0;
            end else begin
                stalled = 1;
            end
            cyc++;
        end
        ser_ready = 1'b0;
        model_out = exp;

        chk("beat_count", 64'(beats), 64'(WIDTH));
        chk("stream_bits", 64'(got_word), 64'(exp));
        chk("last_position", 64'(last_at), 64'(WIDTH - 1));
        chk("last_once", 64'(n_last), 64'(1));
        chk("stall_hold", 64'(hold_bad), 64'(0));
        chk("valid_gap", 64'(vld_bad), 64'(0));
        chk("early_done", 64'(early_done), 64'(0));
        chk("done_pulse", 64'(done), 64'(1));
        chk("word_out", 64'(word_out), 64'(exp));
        chk("rx_count", 64'(rx_count), 64'(n));
        chk("word_occurrences", 64'(model_count(word_out)), 64'(n));
        chk("busy_in_done", 64'(req_ready), 64'(0));
`ifdef PATTERN_GEN_SELFCHECK_EN
        chk("chk_fail", 64'(chk_fail), 64'(0));
`endif
        tick();
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("ready_after_done", 64'(req_ready), 64'(1));
        chk("word_held", 64'(word_out), 64'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_count  = '0;
        req_offset = '0;
        ser_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_ser_valid", 64'(ser_valid), 64'(0));
        chk("rst_ser_bit", 64'(ser_bit), 64'(0));
        chk("rst_ser_last", 64'(ser_last), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_word_out", 64'(word_out), 64'(0));

        run_req(3, 0, 0);
        run_req(15, 0, 0);
        run_req(15, 2, 0);
        run_req(15, 1, 0);
        run_req(1, 31, 0);
        run_req(0, 7, 0);
        run_req(2, 10, 1);

        // Abandon a stream with reset after 12 accepted beats.
        req_valid  = 1'b1;
        req_count  = CNT_W'(5);
        req_offset = '0;
        tick();
        req_valid = 1'b0;
        ser_ready = 1'b1;
        repeat (12) tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(ser_valid), 64'(0));
        chk("rst_mid_ready", 64'(req_ready), 64'(1));
        ser_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_out = '0;
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) done_seen++;
            tick();
        end
        chk("rst_no_done", 64'(done_seen), 64'(0));
        chk("rst_mid_word", 64'(word_out), 64'(0));
        chk("rst_ready_after", 64'(req_ready), 64'(1));
        run_req(1, 0, 0);

        for (int t = 0; t < 20; t++) begin
            run_req(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
